// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: widths, the
// hard-wired zero register and the requester identifiers.
package regfile_write_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic RQ_ALU = 1'b0;
  localparam logic RQ_MDU = 1'b1;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. On contention the requester that did not
// win the previous transfer is granted.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = (last_grant_q == RQ_MDU);
      gnt1 = (last_grant_q == RQ_ALU);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // A grant is always a transfer because ready only rises with valid.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0) begin
      last_grant_d = RQ_ALU;
    end else if (gnt1) begin
      last_grant_d = RQ_MDU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= RQ_MDU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU/load writeback (rq0) and
// the mult/div unit (rq1), and tracks registers awaiting mult/div results.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = regfile_write_arbiter_pkg::DATA_W,
  parameter int ADDR_W = regfile_write_arbiter_pkg::ADDR_W,
  parameter int NREGS  = regfile_write_arbiter_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rq0_valid,
  input  logic [ADDR_W-1:0] rq0_reg,
  input  logic [DATA_W-1:0] rq0_data,
  output logic              rq0_ready,
  input  logic              rq1_valid,
  input  logic [ADDR_W-1:0] rq1_reg,
  input  logic [DATA_W-1:0] rq1_data,
  output logic              rq1_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic              stall,
  output logic [NREGS-1:0]  pending,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data
);

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NREGS-1:0]  pending_q, pending_d;

  logic              xfer;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (rq0_valid),
    .req1  (rq1_valid),
    .gnt0  (rq0_ready),
    .gnt1  (rq1_ready)
  );

  assign xfer     = rq0_ready | rq1_ready;
  assign sel_reg  = rq1_ready ? rq1_reg  : rq0_reg;
  assign sel_data = rq1_ready ? rq1_data : rq0_data;

  // Writes to the zero register are consumed but never enable the write.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (xfer) begin
      reg_write_d  = (sel_reg != REG_ZERO);
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
    end
  end

  // Per-register scoreboard bit; a reservation outranks a same-cycle clear.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pending
    logic set_hit;
    logic clr_hit;
    assign set_hit = rsv_valid && (rsv_reg == ADDR_W'(gi)) && (gi != 0);
    assign clr_hit = rq1_ready && (rq1_reg == ADDR_W'(gi));
    assign pending_d[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : pending_q[gi]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
    end
  end

  assign stall = ((read_reg1 != REG_ZERO) && pending_q[read_reg1]) ||
                 ((read_reg2 != REG_ZERO) && pending_q[read_reg2]);

  assign pending    = pending_q;
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

endmodule
